// File: rtl/sel_mux_pkg.sv
// Shared defaults and helpers for the select-mux family.
// Both the legacy case mux and the registered pipe import this package.
package sel_mux_pkg;

  localparam int SEL_MUX_WIDTH = 4;
  localparam int SEL_MUX_NCH   = 15;
  localparam int SEL_MUX_SEL_W = 4;

  // Code 0 counts as in range: it is the null select, not an error.
  function automatic logic sel_code_ok(input int unsigned c, input int unsigned nch);
    return c <= nch;
  endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Capture/output handshake bundle for sel_mux_pipe.
// The master side drives the channels and the request; the slave side is the mux.
interface sel_mux_pipe_if
  import sel_mux_pkg::*;
#(
  parameter int WIDTH = SEL_MUX_WIDTH,
  parameter int NCH   = SEL_MUX_NCH,
  parameter int SEL_W = SEL_MUX_SEL_W
);

  logic [NCH*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]     sel;
  logic                 enable;
  logic                 scan_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output data_in, sel, enable, scan_en, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  modport slave (
    input  data_in, sel, enable, scan_en, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );

endinterface

// File: rtl/sel_mux_comb.sv
// Purely combinational code -> data/err decode for an NCH-way, 1-based select.
// Unmatched codes fall through to zero, so no X can escape the mux.
module sel_mux_comb
  import sel_mux_pkg::*;
#(
  parameter int WIDTH = SEL_MUX_WIDTH,
  parameter int NCH   = SEL_MUX_NCH,
  parameter int SEL_W = SEL_MUX_SEL_W
) (
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]     code,
  input  logic                 enable,
  output logic [WIDTH-1:0]     data,
  output logic                 err
);

  logic [WIDTH-1:0] hit_data [NCH];
  logic [WIDTH-1:0] sel_or;

  // One-hot AND-OR mux: each channel contributes only when its code matches.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign hit_data[gi] = (code == SEL_W'(gi + 1)) ? data_in[gi*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    sel_or = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_or = sel_or | hit_data[k];
    end
  end

  assign data = enable ? sel_or : '0;
  assign err  = !sel_code_ok(32'(code), NCH);

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered NCH-way select with a one-deep valid/ready output stage and an
// auto-scan code source that walks channels 1..NCH.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int WIDTH = SEL_MUX_WIDTH,
  parameter int NCH   = SEL_MUX_NCH,
  parameter int SEL_W = SEL_MUX_SEL_W
) (
  input logic          clk,
  input logic          rst_n,
  sel_mux_pipe_if.slave bus
);

  if (NCH < 1 || NCH > (2**SEL_W) - 1) begin : g_bad_cfg
    $error("sel_mux_pipe: NCH=%0d does not fit a %0d-bit code", NCH, SEL_W);
  end

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SEL_W-1:0] out_sel_reg, out_sel_next;
  logic             out_err_reg, out_err_next;
  logic [SEL_W-1:0] scan_cnt_reg, scan_cnt_next;

  logic             accept;
  logic [SEL_W-1:0] code;
  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  // Ready looks through the output register so a draining beat can be replaced in the same cycle.
  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign code         = bus.scan_en ? scan_cnt_reg : bus.sel;

  sel_mux_comb #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_decode (
    .data_in (bus.data_in),
    .code    (code),
    .enable  (bus.enable),
    .data    (mux_data),
    .err     (mux_err)
  );

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    out_err_next   = out_err_reg;
    scan_cnt_next  = scan_cnt_reg;
    if (accept) begin
      out_valid_next = 1'b1;
      out_data_next  = mux_data;
      out_sel_next   = code;
      out_err_next   = mux_err;
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
    // The counter only ever holds 1..NCH, so every scanned code is a live channel.
    if (accept && bus.scan_en) begin
      scan_cnt_next = (scan_cnt_reg >= SEL_W'(NCH)) ? SEL_W'(1) : scan_cnt_reg + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_err_reg   <= 1'b0;
      scan_cnt_reg  <= SEL_W'(1);
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      out_err_reg   <= out_err_next;
      scan_cnt_reg  <= scan_cnt_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;
  assign bus.out_err   = out_err_reg;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: three instances (NCH=15, 11, 3) share clock
// and reset; channel k always carries the value k so expected data equals the code.
module tb_sel_mux_pipe;

  logic clk;
  logic rst_n;

  int vec_cnt;
  int miscompare_cnt;

  sel_mux_pipe_if #(.WIDTH(4), .NCH(15), .SEL_W(4)) bus15 ();
  sel_mux_pipe_if #(.WIDTH(4), .NCH(11), .SEL_W(4)) bus11 ();
  sel_mux_pipe_if #(.WIDTH(4), .NCH(3),  .SEL_W(4)) bus3 ();

  sel_mux_pipe #(.WIDTH(4), .NCH(15), .SEL_W(4)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));
  sel_mux_pipe #(.WIDTH(4), .NCH(11), .SEL_W(4)) u_dut11 (.clk(clk), .rst_n(rst_n), .bus(bus11));
  sel_mux_pipe #(.WIDTH(4), .NCH(3),  .SEL_W(4)) u_dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Outputs are read 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] vld, input logic [31:0] dat,
                          input logic [31:0] sl, input logic [31:0] er,
                          input logic [3:0] g_v, input logic [3:0] g_d,
                          input logic [3:0] g_s, input logic [3:0] g_e);
    chk({tag, ".valid"}, 32'(g_v), vld);
    chk({tag, ".data"},  32'(g_d), dat);
    chk({tag, ".sel"},   32'(g_s), sl);
    chk({tag, ".err"},   32'(g_e), er);
  endtask

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    rst_n          = 1'b0;

    bus15.data_in = '0;
    bus11.data_in = '0;
    bus3.data_in  = '0;
    for (int k = 1; k <= 15; k++) bus15.data_in[(k-1)*4 +: 4] = 4'(k);
    for (int k = 1; k <= 11; k++) bus11.data_in[(k-1)*4 +: 4] = 4'(k);
    for (int k = 1; k <= 3;  k++) bus3.data_in[(k-1)*4 +: 4]  = 4'(k);

    bus15.sel = '0; bus15.enable = 1'b1; bus15.scan_en = 1'b0; bus15.in_valid = 1'b0; bus15.out_ready = 1'b0;
    bus11.sel = '0; bus11.enable = 1'b1; bus11.scan_en = 1'b0; bus11.in_valid = 1'b0; bus11.out_ready = 1'b1;
    bus3.sel  = '0; bus3.enable  = 1'b1; bus3.scan_en  = 1'b0; bus3.in_valid  = 1'b0; bus3.out_ready  = 1'b1;

    // Reset state
    #2;
    chk_beat("rst", 0, 0, 0, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
    chk("rst.in_ready", 32'(bus15.in_ready), 1);
    #10;
    rst_n = 1'b1;

    // Basic select
    bus15.sel = 4'd3; bus15.in_valid = 1'b1; bus15.out_ready = 1'b1;
    tick();
    chk_beat("sel3", 1, 3, 3, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));

    // Null code and disabled beat
    bus15.sel = 4'd0;
    tick();
    chk_beat("sel0", 1, 0, 0, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
    bus15.sel = 4'd5; bus15.enable = 1'b0;
    tick();
    chk_beat("dis5", 1, 0, 5, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
    bus15.sel = 4'd15; bus15.enable = 1'b1;
    tick();
    chk_beat("sel15", 1, 15, 15, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));

    // Drain to empty, then backpressure
    bus15.in_valid = 1'b0;
    tick();
    chk_beat("drain", 0, 15, 15, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
    bus15.sel = 4'd7; bus15.in_valid = 1'b1; bus15.out_ready = 1'b0;
    #1;
    chk("bp.in_ready_empty", 32'(bus15.in_ready), 1);
    tick();
    chk_beat("bp.c1", 1, 7, 7, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
    chk("bp.c1.in_ready", 32'(bus15.in_ready), 0);
    bus15.sel = 4'd8;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_beat($sformatf("bp.c%0d", c), 1, 7, 7, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
      chk($sformatf("bp.c%0d.in_ready", c), 32'(bus15.in_ready), 0);
    end
    bus15.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus15.in_ready), 1);
    for (int s = 8; s <= 10; s++) begin
      bus15.sel = 4'(s);
      tick();
      chk_beat($sformatf("b2b.%0d", s), 1, 32'(s), 32'(s), 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));
    end
    bus15.in_valid = 1'b0;
    tick();
    chk_beat("b2b.end", 0, 10, 10, 0, 4'(bus15.out_valid), bus15.out_data, bus15.out_sel, 4'(bus15.out_err));

    // Out-of-range on NCH=11
    bus11.in_valid = 1'b1;
    bus11.sel = 4'd12;
    tick();
    chk_beat("oor12", 1, 0, 12, 1, 4'(bus11.out_valid), bus11.out_data, bus11.out_sel, 4'(bus11.out_err));
    bus11.sel = 4'd15;
    tick();
    chk_beat("oor15", 1, 0, 15, 1, 4'(bus11.out_valid), bus11.out_data, bus11.out_sel, 4'(bus11.out_err));
    bus11.sel = 4'd11;
    tick();
    chk_beat("top11", 1, 11, 11, 0, 4'(bus11.out_valid), bus11.out_data, bus11.out_sel, 4'(bus11.out_err));
    bus11.sel = 4'd13; bus11.enable = 1'b0;
    tick();
    chk_beat("oor13dis", 1, 0, 13, 1, 4'(bus11.out_valid), bus11.out_data, bus11.out_sel, 4'(bus11.out_err));
    bus11.sel = 4'd1; bus11.enable = 1'b1;
    tick();
    chk_beat("low1", 1, 1, 1, 0, 4'(bus11.out_valid), bus11.out_data, bus11.out_sel, 4'(bus11.out_err));
    bus11.in_valid = 1'b0;

    // Scan wrap on NCH=3, then hold and resume
    bus3.scan_en = 1'b1; bus3.sel = 4'd7; bus3.in_valid = 1'b1;
    begin
      logic [3:0] scan_exp [5];
      scan_exp = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk_beat($sformatf("scan%0d", i), 1, 32'(scan_exp[i]), 32'(scan_exp[i]), 0,
                 4'(bus3.out_valid), bus3.out_data, bus3.out_sel, 4'(bus3.out_err));
      end
    end
    bus3.scan_en = 1'b0; bus3.sel = 4'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_beat($sformatf("hold%0d", i), 1, 2, 2, 0, 4'(bus3.out_valid), bus3.out_data, bus3.out_sel, 4'(bus3.out_err));
    end
    bus3.scan_en = 1'b1; bus3.sel = 4'd7;
    tick();
    chk_beat("resume0", 1, 3, 3, 0, 4'(bus3.out_valid), bus3.out_data, bus3.out_sel, 4'(bus3.out_err));
    tick();
    chk_beat("resume1", 1, 1, 1, 0, 4'(bus3.out_valid), bus3.out_data, bus3.out_sel, 4'(bus3.out_err));

    // Asynchronous reset between edges while a beat is held
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus3.out_valid), 0);
    chk("arst.sel", 32'(bus3.out_sel), 0);
    chk("arst.in_ready", 32'(bus3.in_ready), 1);
    #2;
    rst_n = 1'b1;
    tick();
    chk_beat("post_rst0", 1, 1, 1, 0, 4'(bus3.out_valid), bus3.out_data, bus3.out_sel, 4'(bus3.out_err));
    tick();
    chk_beat("post_rst1", 1, 2, 2, 0, 4'(bus3.out_valid), bus3.out_data, bus3.out_sel, 4'(bus3.out_err));
    bus3.in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/sel_mux_pipe.md
Name: sel_mux_pipe

Overview:
- Parametrised, registered successor to the team's case-based N-way select mux.
- Selects one of NCH channels of WIDTH bits by a 1-based code. Code 0 and out-of-range codes return zero.
- Adds a valid/ready handshake on the output stage, an out-of-range error flag, and an auto-scan mode that walks all channels in turn.
- Sits between parallel status/data sources and a single serial consumer (debug readout, telemetry packer).

Parameters:
- WIDTH, 4, bits per channel.
- NCH, 15, number of selectable channels (1..2**SEL_W-1).
- SEL_W, 4, width of the select code.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  NCH*WIDTH  channel k (1-based) occupies bits [k*WIDTH-1 : (k-1)*WIDTH].
- sel  in  SEL_W  select code; used when scan_en=0.
- enable  in  1  when 0, the accepted beat carries zero data regardless of code.
- scan_en  in  1  when 1, the internal scan counter supplies the code and sel is ignored.
- in_valid  in  1  request to capture one beat.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  code that produced out_data.
- out_err  out  1  the code was > NCH.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0, out_err=0.
  - Scan counter = 1.
  - in_ready follows its equation, so it reads 1 during reset.
- Handshake:
  - in_ready = !out_valid || out_ready (single-stage pipeline, combinational ready).
  - Accept occurs when in_valid && in_ready.
  - On accept, out_* load at the next edge and out_valid=1.
  - If out_valid && out_ready && !accept, then out_valid clears to 0 and out_data/out_sel/out_err hold their values.
  - Simultaneous drain and accept: the new beat replaces the old with no bubble, giving full throughput of 1 beat/cycle.
  - While out_valid && !out_ready, all out_* hold stable.
- Latency: 1 cycle from accept to out_valid.
- Code source: code = scan_en ? scan_cnt : sel, sampled at accept.
- Data selection for code c:
  - enable=0: out_data=0. out_err is still computed from c. out_sel=c.
  - c=0: out_data=0, out_err=0.
  - 1 <= c <= NCH: out_data = channel c, out_err=0.
  - c > NCH: out_data=0, out_err=1.
- Scan counter:
  - Advances only on an accept with scan_en=1.
  - Sequence is 1, 2, ..., NCH, then wraps to 1. It never produces 0 or any code > NCH.
  - Holds while scan_en=0.
  - The scan_en 0->1 transition resumes from the held value; it does not restart.
- Reset asserted mid-transfer: any pending beat is dropped and out_valid falls immediately (asynchronous).
- Width rules: SEL_W must satisfy NCH <= 2**SEL_W-1; this is checked by an elaboration-time assertion. The comparison c > NCH is unsigned at SEL_W bits.
- No X propagation: the mux default arm is 0.

Decomposition:
- Shared package sel_mux_pkg:
  - Default WIDTH, NCH and SEL_W constants.
  - Function sel_code_ok(c, nch) returning in-range.
- One natural sub-module, sel_mux_comb: purely combinational code->data/err decode, reusable by the legacy mux.
- The top level holds the output register, the handshake logic and the scan counter.

Test Plan:
- Basic select: reset, WIDTH=4, NCH=15, channel k data=k, enable=1, sel=3, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=4'h3, out_sel=3, out_err=0.
- Null/disabled: sel=0 -> out_data=0, err=0. Then sel=5 with enable=0 -> out_data=0, out_sel=5, err=0.
- Out-of-range: NCH=11, sel=12 and sel=15 -> out_data=0, out_err=1 on each beat; sel=11 -> channel 11 data, err=0.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> first beat held stable, in_ready=0 from cycle 2. Raise out_ready -> back-to-back beats, 1 per cycle, none lost or duplicated.
- Scan wrap: NCH=3, scan_en=1, sel=7, continuous accepts -> out_sel sequence 1,2,3,1,2. Drop scan_en for 2 accepts (sel=2), then re-enable -> scan resumes at the held counter value.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 -> out_valid=0 immediately. After release, the first scan beat has out_sel=1.
